prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program sequencer that owns the program-memory address bus, fetching 42-bit instruction words from the combinational program memory and issuing them one at a time to the execute stage over a valid/ready handshake. It keeps the program counter and accepts branch redirects from execute. It stops on program end, an external halt, or an address-tag fault. It sits between the program memory and the execute unit and is the only master of the program-memory address.

## Interface
- ADDR_W, 4, program counter / memory address width
- INSTR_W, 42, instruction word width
- PROG_LEN, 7, number of valid program words; valid addresses are 0..PROG_LEN-1
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  pulse; begins the program at address 0 from IDLE or DONE, ignored otherwise
- pm_addr  out  ADDR_W  program-memory address, driven directly from the pc register
- pm_line  in  ADDR_W+INSTR_W  memory line {tag, instr}; tag in the top ADDR_W bits
- issue_valid  out  1  issue_instr/issue_pc are valid
- issue_instr  out  INSTR_W  fetched instruction
- issue_pc  out  ADDR_W  address of issue_instr
- issue_ready  in  1  execute accepts the instruction
- redirect_valid  in  1  branch taken; sampled only on the issue handshake cycle
- redirect_pc  in  ADDR_W  branch target
- halt_req  in  1  stop request
- busy  out  1  state is FETCH or ISSUE
- done  out  1  state is DONE
- err  out  1  sticky tag-mismatch fault, cleared by start

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: on start, pc<=0 and go to FETCH.
- FETCH: if the pm_line tag differs from pc, set err<=1 and go to DONE. Otherwise latch issue_instr<=pm_line[INSTR_W-1:0], issue_pc<=pc, issue_valid<=1, and go to ISSUE.
- ISSUE: hold all issue_* outputs stable while issue_valid=1 and issue_ready=0.
- On handshake (issue_valid and issue_ready), clear issue_valid.
  - Compute next = redirect_valid ? redirect_pc : pc+1, in ADDR_W+1 bits so 2^ADDR_W-1 plus 1 does not wrap.
  - If next >= PROG_LEN, go to DONE. Otherwise pc<=next and go to FETCH.
- halt_req in FETCH or ISSUE: go to DONE at the next edge and clear issue_valid.
  - A handshake in the same cycle still counts as an accepted issue, and redirect is ignored.
  - halt_req has priority over the tag check.
- DONE: done=1. On start, pc<=0, err<=0, and go to FETCH. halt_req is ignored in IDLE and DONE.
- Reset in any state, including mid-handshake, returns everything to reset values and drops issue_valid in the same edge.

## Timing
- Reset values: pc=0, state IDLE, pm_addr=0, issue_valid=0, issue_instr=0, issue_pc=0, busy=0, done=0, err=0.
- start edge to issue_valid=1 takes 2 cycles (IDLE→FETCH, FETCH→ISSUE).
- Throughput is 1 instruction per 2 cycles with issue_ready held high.
- Handshake edge to next issue_valid is 2 cycles.
- pm_addr changes only on pc updates. The memory is combinational, so pm_line is sampled in FETCH in the same cycle pm_addr is stable.
- busy, done and err are registered state outputs with no combinational path from inputs.
- issue_valid never depends combinationally on issue_ready.

## Structure
- Shared package sincere_pkg holds:
  - ADDR_W and INSTR_W
  - instruction field slices: type [41:40], opcode [39:36], A [35:24], B [23:12], C [11:0]
  - the sequencer state enum
- Single module, no sub-module; the next-pc logic and issue register stay inline.

## Test plan
- Linear run, PROG_LEN=7, issue_ready=1: issue_pc is 0,1,…,6 in order, issue_instr matches each memory word, done=1 after the 7th handshake, and 14 cycles elapse from start to the last handshake.
- Back-pressure: issue_ready low for 5 cycles at pc=2 → issue_valid, issue_instr and issue_pc are held unchanged, then the sequence resumes at pc=3.
- Redirects:
  - redirect_valid=1, redirect_pc=0 on the handshake at pc=4 → next issue_pc=0.
  - redirect_pc=9 → done, with no further issue.
- halt_req asserted mid-ISSUE together with issue_ready=1 at pc=3 → pc 3 is accepted, DONE on the next edge, and redirect is ignored.
- Tag fault: memory returns tag 5 at pc=2 → err=1 and done=1, with no issue of pc 2. A following start clears err and restarts at pc 0.
- Reset: rst=0 during ISSUE at pc=5 → all outputs take reset values on the next edge, and a start after release begins at pc 0.

Source files
------------

// File: rtl/sincere_pkg.sv
// Shared types and widths for the program sequencer: address/instruction widths,
// instruction field positions and the sequencer state encoding.
package sincere_pkg;

    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 42;

    // Instruction field bit positions (msb/lsb inclusive)
    localparam int TYPE_MSB = 41;
    localparam int TYPE_LSB = 40;
    localparam int OPC_MSB  = 39;
    localparam int OPC_LSB  = 36;
    localparam int A_MSB    = 35;
    localparam int A_LSB    = 24;
    localparam int B_MSB    = 23;
    localparam int B_LSB    = 12;
    localparam int C_MSB    = 11;
    localparam int C_LSB    = 0;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [1:0] instr_type(input instr_t i);
        return i[TYPE_MSB:TYPE_LSB];
    endfunction

    function automatic logic [3:0] instr_opcode(input instr_t i);
        return i[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [11:0] instr_a(input instr_t i);
        return i[A_MSB:A_LSB];
    endfunction

    function automatic logic [11:0] instr_b(input instr_t i);
        return i[B_MSB:B_LSB];
    endfunction

    function automatic logic [11:0] instr_c(input instr_t i);
        return i[C_MSB:C_LSB];
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Program-memory address/line bus plus the issue and redirect channels to execute.
interface prog_sequencer_if;
    import sincere_pkg::*;

    logic [ADDR_W-1:0]         pm_addr;
    logic [ADDR_W+INSTR_W-1:0] pm_line;
    logic                      issue_valid;
    logic [INSTR_W-1:0]        issue_instr;
    logic [ADDR_W-1:0]         issue_pc;
    logic                      issue_ready;
    logic                      redirect_valid;
    logic [ADDR_W-1:0]         redirect_pc;

    modport master (
        output pm_addr,
        input  pm_line,
        output issue_valid,
        output issue_instr,
        output issue_pc,
        input  issue_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  pm_addr,
        output pm_line,
        input  issue_valid,
        input  issue_instr,
        input  issue_pc,
        output issue_ready,
        input  redirect_valid,
        input  redirect_pc
    );

endinterface

// File: rtl/prog_sequencer.sv
// Fetches tagged words from combinational program memory and issues one per handshake;
// 2 cycles start-to-issue and handshake-to-issue, outputs held while issue_ready is low.
module prog_sequencer
    import sincere_pkg::*;
#(
    parameter int PROG_LEN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    output logic              busy,
    output logic              done,
    output logic              err,
    prog_sequencer_if.master  bus
);

    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

    seq_state_t         state;
    logic [ADDR_W-1:0]  pc;
    logic               issue_valid;
    logic [INSTR_W-1:0] issue_instr;
    logic [ADDR_W-1:0]  issue_pc;

    logic [ADDR_W-1:0]  line_tag;
    logic [INSTR_W-1:0] line_instr;
    logic [ADDR_W:0]    next_pc;

    assign line_tag   = bus.pm_line[ADDR_W+INSTR_W-1:INSTR_W];
    assign line_instr = bus.pm_line[INSTR_W-1:0];

    // One extra bit so the top address plus one lands past the program instead of wrapping to 0
    always_comb begin
        next_pc = {1'b0, pc} + (ADDR_W+1)'(1);
        if (bus.redirect_valid) begin
            next_pc = {1'b0, bus.redirect_pc};
        end
    end

    assign bus.pm_addr     = pc;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_instr = issue_instr;
    assign bus.issue_pc    = issue_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_pc    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (halt_req) begin
                        state       <= S_DONE;
                        issue_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (line_tag != pc) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        issue_instr <= line_instr;
                        issue_pc    <= pc;
                        issue_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // issue_valid is always set here; a halt wins over any redirect
                    if (halt_req) begin
                        state       <= S_DONE;
                        issue_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (bus.issue_ready) begin
                        issue_valid <= 1'b0;
                        if (next_pc >= PROG_END) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc    <= next_pc[ADDR_W-1:0];
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        pc    <= '0;
                        err   <= 1'b0;
                        state <= S_FETCH;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    issue_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: linear run, back-pressure, redirects, halt, tag fault, reset.
module tb_prog_sequencer;
    import sincere_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic halt_req;
    logic busy;
    logic done;
    logic err;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_start;
    int   t_last;
    logic       fault_en;
    logic [3:0] fault_addr;

    prog_sequencer_if bus ();

    prog_sequencer #(.PROG_LEN(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt_req (halt_req),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word at address a: type=a[1:0], opcode=a^4'hA, A=0x100+a, B=0xABC, C=7*a
    function automatic logic [INSTR_W-1:0] instr_at(input logic [3:0] a);
        logic [11:0] c;
        c = 12'(a) * 12'd7;
        return {a[1:0], a ^ 4'hA, 12'h100 + 12'(a), 12'hABC, c};
    endfunction

    always_comb begin
        bus.pm_line = {bus.pm_addr, instr_at(bus.pm_addr)};
        if (fault_en && bus.pm_addr == fault_addr) begin
            bus.pm_line = {4'd5, instr_at(bus.pm_addr)};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", {63'b0, busy}, 64'd1);
    endtask

    // Edge FETCH->ISSUE: the word at p must be presented
    task automatic expect_issue(input int p);
        step();
        check($sformatf("valid_pc%0d", p), {63'b0, bus.issue_valid}, 64'd1);
        check($sformatf("issue_pc%0d", p), {60'b0, bus.issue_pc}, 64'(p));
        check($sformatf("instr_pc%0d", p), {22'b0, bus.issue_instr}, {22'b0, instr_at(4'(p))});
    endtask

    task automatic accept();
        step();
        check("valid_drop", {63'b0, bus.issue_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        fault_en = 1'b0;
        fault_addr = 4'd2;
        bus.issue_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 4'd0;
        step();
        step();
        check("rst_valid", {63'b0, bus.issue_valid}, 64'd0);
        check("rst_pm_addr", {60'b0, bus.pm_addr}, 64'd0);
        check("rst_instr", {22'b0, bus.issue_instr}, 64'd0);
        check("rst_flags", {61'b0, busy, done, err}, 64'd0);
        rst = 1'b1;

        // halt in IDLE is ignored
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("idle_halt", {62'b0, busy, done}, 64'd0);

        // Linear run
        do_start();
        t_start = cyc;
        t_last = 0;
        for (int p = 0; p < 7; p++) begin
            expect_issue(p);
            accept();
            t_last = cyc;
        end
        check("lin_done", {62'b0, done, busy}, 64'b10);
        check("lin_cycles", 64'(t_last - t_start), 64'd14);
        check("lin_pm_addr", {60'b0, bus.pm_addr}, 64'd6);

        // Back-pressure at pc 2
        do_start();
        expect_issue(0); accept();
        expect_issue(1); accept();
        expect_issue(2);
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {63'b0, bus.issue_valid}, 64'd1);
            check("bp_pc", {60'b0, bus.issue_pc}, 64'd2);
            check("bp_instr", {22'b0, bus.issue_instr}, {22'b0, instr_at(4'd2)});
        end
        bus.issue_ready = 1'b1;
        accept();
        for (int p = 3; p < 7; p++) begin
            expect_issue(p);
            accept();
        end
        check("bp_done", {63'b0, done}, 64'd1);

        // Redirect to 0 at pc 4, then out of range at pc 1
        do_start();
        for (int p = 0; p < 5; p++) begin
            expect_issue(p);
            if (p < 4) accept();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 4'd0;
        accept();
        bus.redirect_valid = 1'b0;
        expect_issue(0); accept();
        expect_issue(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 4'd9;
        accept();
        bus.redirect_valid = 1'b0;
        check("redir9_done", {62'b0, done, busy}, 64'b10);
        step(); step();
        check("redir9_noissue", {63'b0, bus.issue_valid}, 64'd0);

        // Halt together with a handshake at pc 3; redirect ignored
        do_start();
        for (int p = 0; p < 4; p++) begin
            expect_issue(p);
            if (p < 3) accept();
        end
        halt_req = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 4'd0;
        step();
        halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        check("halt_done", {62'b0, done, busy}, 64'b10);
        check("halt_valid", {63'b0, bus.issue_valid}, 64'd0);
        check("halt_pm_addr", {60'b0, bus.pm_addr}, 64'd3);

        // Tag fault at pc 2
        fault_en = 1'b1;
        do_start();
        expect_issue(0); accept();
        expect_issue(1); accept();
        step();
        check("fault_flags", {61'b0, err, done, bus.issue_valid}, 64'b110);
        step();
        check("fault_noissue", {63'b0, bus.issue_valid}, 64'd0);
        fault_en = 1'b0;
        do_start();
        check("fault_err_clr", {62'b0, err, done}, 64'd0);
        expect_issue(0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt2_done", {63'b0, done}, 64'd1);

        // Reset mid-handshake at pc 5
        do_start();
        for (int p = 0; p < 6; p++) begin
            expect_issue(p);
            if (p < 5) accept();
        end
        rst = 1'b0;
        step();
        check("mrst_valid", {63'b0, bus.issue_valid}, 64'd0);
        check("mrst_pc", {60'b0, bus.issue_pc}, 64'd0);
        check("mrst_instr", {22'b0, bus.issue_instr}, 64'd0);
        check("mrst_pm_addr", {60'b0, bus.pm_addr}, 64'd0);
        check("mrst_flags", {61'b0, busy, done, err}, 64'd0);
        rst = 1'b1;
        step();
        check("mrst_idle", {62'b0, busy, done}, 64'd0);
        do_start();
        expect_issue(0);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
